// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef logic [GROUP_W-1:0] nibble_t;

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead group: sum nibble plus carries from generate/propagate.
// Latency: purely combinational.
// Backpressure: not applicable.
//
// Ports: a, b  - operand nibbles (b already inverted by the caller for subtract)
//        ci    - carry into bit 0 of the group
//        s     - sum nibble
//        co    - carry out of bit 3 (c4)
//        c3    - carry into bit 3, used by the top stage for signed overflow
module cla4_group
  import cla_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co,
  output logic    c3
);

  nibble_t g;
  nibble_t p;
  logic    c1;
  logic    c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/ci, so no carry waits on another.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract, one 4-bit lookahead group per stage, valid/ready handshake.
// Latency: WIDTH/4 cycles from accepted input to out_valid, one result per cycle.
// Backpressure: global stall; when out_valid && !out_ready every register holds and in_ready=0.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, cin, sub;
//        out_valid/out_ready with sum, cout (1 = no borrow when subtracting), ovf (signed).
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP_W;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NSTG; k++) begin : stg
    // RW: operand bits still unprocessed after this stage; SW: sum bits finished so far.
    localparam int RW = WIDTH - GROUP_W * (k + 1);
    localparam int SW = GROUP_W * (k + 1);

    // Operand bits [WIDTH-1 : 4k] as seen by this stage; the low nibble is its group.
    logic [RW+GROUP_W-1:0] op_a;
    logic [RW+GROUP_W-1:0] op_b;
    logic                  ci;
    logic                  v_in;
    nibble_t               gs;
    logic                  gco;
    logic                  gc3;

    logic                  v_q;
    logic                  c_q;
    logic [SW-1:0]         s_q;

    if (k == 0) begin : head
      // Subtract is A + ~B + 1, so cin is ignored when sub=1.
      assign op_a = a;
      assign op_b = sub ? ~b : b;
      assign ci   = sub | cin;
      assign v_in = in_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q <= '0;
        end else if (en) begin
          s_q <= gs;
        end
      end
    end else begin : body
      assign op_a = stg[k-1].fwd.a_q;
      assign op_b = stg[k-1].fwd.b_q;
      assign ci   = stg[k-1].c_q;
      assign v_in = stg[k-1].v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q <= '0;
        end else if (en) begin
          s_q <= {gs, stg[k-1].s_q};
        end
      end
    end

    cla4_group u_grp (
      .a  (op_a[GROUP_W-1:0]),
      .b  (op_b[GROUP_W-1:0]),
      .ci (ci),
      .s  (gs),
      .co (gco),
      .c3 (gc3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= gco;
      end
    end

    // Skew registers: only the operand bits later stages still need move forward.
    if (k < NSTG - 1) begin : fwd
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= op_a[RW+GROUP_W-1:GROUP_W];
          b_q <= op_b[RW+GROUP_W-1:GROUP_W];
        end
      end
    end

    // Only the top group's carry into the MSB matters for signed overflow.
    if (k == NSTG - 1) begin : tail
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= gc3 ^ gco;
        end
      end
    end else begin : mid
      logic unused_c3;
      assign unused_c3 = gc3;
    end
  end

  assign out_valid = stg[NSTG-1].v_q;
  assign sum       = stg[NSTG-1].s_q;
  assign cout      = stg[NSTG-1].c_q;
  assign ovf       = stg[NSTG-1].tail.ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
module tb_pipe_cla_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;
  int run_len    = 0;
  int max_run    = 0;

  exp_t exp_q[$];

  // Directed vectors: {a, b, cin, sub, expected sum, cout, ovf}, all hand-computed.
  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t b2b[8];
  vec_t stl[4];

  pipe_cla_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one operand set after a rising edge and holds it until in_ready is seen.
  task automatic drive(input vec_t v, input bit push);
    bit ok;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = v.va;
    b        = v.vb;
    cin      = v.vcin;
    sub      = v.vsub;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else if (push) begin
      e.s = v.es;
      e.c = v.ec;
      e.o = v.eo;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: sum=%h cout=%b ovf=%b with nothing expected", sum, cout, ovf);
      end else begin
        e = exp_q.pop_front();
        chk("result{sum,cout,ovf}", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    int   cnt;

    b2b[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    b2b[1] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    b2b[2] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
    b2b[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    b2b[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    b2b[5] = '{16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    b2b[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    b2b[7] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    stl[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    stl[1] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    stl[2] = '{16'hABCD, 16'h0BCD, 1'b0, 1'b1, 16'hA000, 1'b1, 1'b0};
    stl[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Carry rippling through all four groups, with latency measurement.
    v = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    drive(v, 1'b1);
    idle();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency_cycles", lat, 32'd4);
    drain();

    v = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    drive(v, 1'b1);
    idle();
    drain();

    v = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    drive(v, 1'b1);
    idle();
    drain();

    // Eight back-to-back transfers must come out as one unbroken run.
    max_run = 0;
    for (int i = 0; i < 8; i++) drive(b2b[i], 1'b1);
    idle();
    drain();
    repeat (2) @(negedge clk);
    chk("b2b_run_length", max_run, 32'd8);

    // Fill the pipe with out_ready low, then hold three cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(stl[i], 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_held_output", {14'd0, out_valid, sum, cout}, {14'd0, 1'b1, 16'h0003, 1'b0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("stall_no_leftover", exp_q.size(), 32'd0);

    // Two transfers, then reset mid-flight: neither may ever appear.
    v = '{16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0};
    drive(v, 1'b0);
    v = '{16'h2222, 16'h2222, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0};
    drive(v, 1'b0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_sum", {16'd0, sum}, 32'd0);
    repeat (2) @(negedge clk);

    // Release reset with a transfer already waiting for the first edge.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 16'h0003;
    b        = 16'h0004;
    cin      = 1'b1;
    sub      = 1'b0;
    exp_q.push_back('{16'h0008, 1'b0, 1'b0});
    idle();
    lat = 0;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (lat == 0) lat = i;
      end
    end
    chk("post_reset_latency", lat, 32'd4);
    chk("post_reset_result_count", cnt, 32'd1);
    chk("final_scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have derived localparam NSTG = WIDTH/4, meaning the number of pipeline stages, one 4-bit lookahead group per stage.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: operands on a, b, cin and sub are valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 Port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-011 Port out_valid, output, 1 bit: result fields are valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-013 Port sum, output, WIDTH bits: the result.
REQ-014 Port cout, output, 1 bit: carry out of the MSB; for sub=1, 1 means no borrow.
REQ-015 Port ovf, output, 1 bit: signed (two's-complement) overflow.

Function
REQ-016 SHALL treat sub=1 as A + ~B + 1: B is inverted and the effective carry-in is forced to 1, so cin is ignored.
REQ-017 SHALL have stage k (0..NSTG-1) compute bits [4k+3:4k] with one 4-bit carry-lookahead group, from the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-018 SHALL compute each group's generate/propagate per bit as g=a&b and p=a^b, with carries c1..c4 in lookahead (sum-of-products) form, not rippled.
REQ-019 SHALL carry the still-unprocessed upper operand bits and the already-computed lower sum bits forward in skew registers, one stage per cycle.
REQ-020 SHALL use a global stall: en = !out_valid || out_ready; in_ready = en; when en=0, no pipeline register changes.
REQ-021 SHALL accept a transfer when in_valid && in_ready, and return the result NSTG cycles later if there are no stalls; each stage holds a valid bit.
REQ-022 SHALL inject a bubble (stage-0 valid=0) when in_valid=0 && en=1; bubbles never produce out_valid.
REQ-023 SHALL keep sum, cout and ovf stable while out_valid=1 && out_ready=0.
REQ-024 SHALL sustain throughput of one result per cycle with out_ready held at 1.
REQ-025 SHALL compute ovf as the carry into bit WIDTH-1 XOR cout, for both add and subtract.
REQ-026 SHALL wrap the sum modulo 2^WIDTH; the carry out is reported only on cout.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all stage valid bits, all data/carry registers, out_valid, sum, cout and ovf to 0.
REQ-028 SHALL drive in_ready=1 after reset.
REQ-029 SHALL discard in-flight operations when reset is asserted mid-operation; none emerge after release.
REQ-030 SHALL accept a transfer in the first clk edge after rst_n deasserts.

Structure
REQ-031 SHALL place in shared package cla_pkg: constant GROUP_W=4 and typedef nibble_t (4-bit logic).
REQ-032 SHALL implement the 4-bit lookahead group as combinational sub-module cla4_group (inputs a, b, ci; outputs s, co, c3), instantiated NSTG times via generate.
REQ-033 SHALL contain no combinational path from in_valid to out_valid; the only combinational output paths are out_ready to in_ready, and the data paths that come from registers.

Verification (WIDTH=16, NSTG=4)
REQ-034 SHALL cover: a=0xFFFF, b=0x0001, sub=0, cin=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0 (carry crosses all groups).
REQ-035 SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 SHALL cover: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-037 SHALL cover: 8 back-to-back transfers with out_ready=1 -> 8 consecutive out_valid cycles, in order, results matching a reference model.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, output held constant, no loss or duplication after release.
REQ-039 SHALL cover: rst_n pulsed low 2 cycles after 2 transfers -> out_valid=0 immediately, and neither result ever appears.
